// File: rtl/verin_bp_pkg.sv
// Shared register-map constants for the actuator push-button controller.
package verin_bp_pkg;
  localparam logic [1:0]  ADDR_DATA    = 2'd0;
  localparam logic [1:0]  ADDR_MASK    = 2'd1;
  localparam logic [1:0]  ADDR_EDGE    = 2'd2;
  localparam logic [1:0]  ADDR_CTRL    = 2'd3;
  localparam int          DB_EN_BIT    = 0;
  localparam int          EDGE_SEL_BIT = 1;
  localparam logic [31:0] CTRL_RST     = 32'h1;
endpackage

// File: rtl/verin_bp_debounce.sv
// One button lane: two-flop synchroniser, debounce counter and stable flop.
// rise/fall are combinational and flag the clock edge on which stable will change.
module verin_bp_debounce
  import verin_bp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic db_en,
  output logic stable,
  output logic rise,
  output logic fall
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;

  // Bypass accepts every cycle; otherwise only once the difference has persisted long enough.
  assign w_accept = !db_en || ((r_sync2 != r_stable) && (r_cnt == CNT_MAX));
  assign rise     = w_accept &  r_sync2 & ~r_stable;
  assign fall     = w_accept & ~r_sync2 &  r_stable;
  assign stable   = r_stable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      if (!db_en) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/verin_bp_ctrl.sv
// Avalon-MM push-button controller: debounced DATA, IRQ_MASK, sticky EDGE_CAP, CTRL.
// Define VERIN_BP_BOTH_EDGE_EN to add CTRL.EDGE_SEL (capture falling edges too).
module verin_bp_ctrl
  import verin_bp_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;
  logic [31:0]      w_rdata;
  logic [31:0]      r_readdata;
  logic             r_db_en;
  logic             r_irq;
  logic             w_edge_sel;
  logic             w_unused;

  assign w_unused = ^{writedata, w_fall};

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      verin_bp_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_db (
        .clk   (clk),
        .reset (reset),
        .din   (in_port[gi]),
        .db_en (r_db_en),
        .stable(w_stable[gi]),
        .rise  (w_rise[gi]),
        .fall  (w_fall[gi])
      );
    end
  endgenerate

`ifdef VERIN_BP_BOTH_EDGE_EN
  logic r_edge_sel;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_edge_sel <= CTRL_RST[EDGE_SEL_BIT];
    end else if (write && address == ADDR_CTRL) begin
      r_edge_sel <= writedata[EDGE_SEL_BIT];
    end
  end
  assign w_edge_sel = r_edge_sel;
  assign w_set      = w_rise | (r_edge_sel ? w_fall : '0);
`else
  assign w_edge_sel = 1'b0;
  assign w_set      = w_rise;
`endif

  assign w_clr = (write && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_DATA: w_rdata[WIDTH-1:0] = w_stable;
      ADDR_MASK: w_rdata[WIDTH-1:0] = r_mask;
      ADDR_EDGE: w_rdata[WIDTH-1:0] = r_edge;
      default: begin
        w_rdata[DB_EN_BIT]    = r_db_en;
        w_rdata[EDGE_SEL_BIT] = w_edge_sel;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask     <= '0;
      r_edge     <= '0;
      r_db_en    <= CTRL_RST[DB_EN_BIT];
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (write && address == ADDR_MASK) r_mask  <= writedata[WIDTH-1:0];
      if (write && address == ADDR_CTRL) r_db_en <= writedata[DB_EN_BIT];
      // A new edge on the same cycle as a write-1-clear keeps the bit set.
      r_edge <= (r_edge & ~w_clr) | w_set;
      r_irq  <= |(r_edge & r_mask);
      if (read) r_readdata <= w_rdata;
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;
endmodule

// File: tb/tb_verin_bp_ctrl.sv
// Directed self-checking bench for verin_bp_ctrl (WIDTH=4, DEBOUNCE_CYCLES=4).
module tb_verin_bp_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [3:0]  in_port = '0;
  logic        irq;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] ctrl_sel_exp;
  logic [31:0] fall_exp;

  verin_bp_ctrl #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [1:0] a);
    address = a; read = 1'b1;
    tick();
    read = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  initial begin
`ifdef VERIN_BP_BOTH_EDGE_EN
    ctrl_sel_exp = 32'h2;
    fall_exp     = 32'h1;
`else
    ctrl_sel_exp = 32'h0;
    fall_exp     = 32'h0;
`endif
    tick(); tick();
    #2 reset = 1'b0;
    tick();
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    do_read(2'd3); check("rst_ctrl", readdata, 32'h1);
    do_read(2'd1); check("rst_mask", readdata, 32'h0);

    // Glitch: 3 cycles high never reaches the stable value.
    in_port[1] = 1'b1;
    repeat (3) tick();
    in_port[1] = 1'b0;
    repeat (6) tick();
    do_read(2'd0); check("glitch_data", readdata, 32'h0);
    do_read(2'd2); check("glitch_edge", readdata, 32'h0);

    // Clean press: stable updates on the 6th edge after the pin change.
    in_port[0] = 1'b1;
    repeat (5) tick();
    do_read(2'd0); check("press_data_e6", readdata, 32'h0);
    do_read(2'd0); check("press_data_e7", readdata, 32'h1);
    do_read(2'd2); check("press_edge", readdata, 32'h1);
    do_write(2'd2, 32'h1);
    do_read(2'd2); check("edge_clear0", readdata, 32'h0);

    // Interrupt on bit 2.
    do_write(2'd1, 32'h4);
    do_read(2'd1); check("mask_rb", readdata, 32'h4);
    in_port[2] = 1'b1;
    repeat (6) tick();
    check("irq_at_set", {31'b0, irq}, 32'h0);
    tick();
    check("irq_after_set", {31'b0, irq}, 32'h1);
    do_read(2'd2); check("irq_edge", readdata, 32'h4);
    do_write(2'd2, 32'h4);
    check("irq_at_clear", {31'b0, irq}, 32'h1);
    tick();
    check("irq_after_clear", {31'b0, irq}, 32'h0);
    do_read(2'd2); check("irq_edge_clr", readdata, 32'h0);

    // Clear and set of bit 3 on the same edge: set wins.
    in_port[3] = 1'b1;
    repeat (5) tick();
    do_write(2'd2, 32'h8);
    do_read(2'd2); check("collide_edge", readdata, 32'h8);
    do_read(2'd0); check("collide_data", readdata, 32'hD);
    do_write(2'd0, 32'hF);
    do_read(2'd0); check("data_ro", readdata, 32'hD);

    // EDGE_SEL exists only with the both-edge build.
    do_write(2'd3, 32'h2);
    do_read(2'd3); check("ctrl_sel", readdata, ctrl_sel_exp);
    do_write(2'd3, 32'h3 & ~32'h1 | ctrl_sel_exp);
    do_write(2'd2, 32'hF);

    // Bypass: 3-cycle latency.
    in_port[0] = 1'b0;
    repeat (2) tick();
    do_read(2'd0); check("byp_rel_e3", readdata, 32'hD);
    do_read(2'd0); check("byp_rel_e4", readdata, 32'hC);
    do_read(2'd2); check("byp_fall_edge", readdata, fall_exp);
    do_write(2'd2, 32'hF);
    in_port[0] = 1'b1;
    repeat (2) tick();
    do_read(2'd0); check("byp_prs_e3", readdata, 32'hC);
    do_read(2'd0); check("byp_prs_e4", readdata, 32'hD);
    do_read(2'd2); check("byp_rise_edge", readdata, 32'h1);

    // Async reset while irq and readdata are non-zero.
    do_write(2'd1, 32'h1);
    tick();
    check("irq_pre_rst", {31'b0, irq}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_rd", readdata, 32'h0);
    check("async_rst_irq", {31'b0, irq}, 32'h0);
    #2 reset = 1'b0;
    tick();
    do_read(2'd3); check("post_rst_ctrl", readdata, 32'h1);
    do_read(2'd1); check("post_rst_mask", readdata, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
